video_timing_gen: RTL and testbench
===================================

# video_timing_gen

Parametrised raster timing generator for the video controller: produces horizontal/vertical sync, blanking, pixel coordinates and frame/line markers for any display geometry, replacing fixed-geometry timing logic. Sits between the pixel clock domain and the framebuffer reader; its coordinates address the framebuffer and its syncs drive the video interface and the screen model.

## Interface
- HDISP, 800, active pixels per line
- VDISP, 480, active lines per frame
- HFP / HPULSE / HBP, 40 / 48 / 40, horizontal front porch, sync, back porch (pixels)
- VFP / VPULSE / VBP, 13 / 3 / 29, vertical front porch, sync, back porch (lines)
- SYNC_POL, 0, 0 = syncs active-low, 1 = active-high
- Derived: HTOT = HDISP+HFP+HPULSE+HBP, VTOT likewise; XW = $clog2(HTOT), YW = $clog2(VTOT)
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- en  in  1  run enable; low holds generator idle
- hs  out  1  horizontal sync (polarity per SYNC_POL)
- vs  out  1  vertical sync
- blank  out  1  high outside active area
- x  out  XW  current pixel column (raw counter)
- y  out  YW  current line (raw counter)
- line_start  out  1  one-cycle pulse at x==0
- frame_start  out  1  one-cycle pulse at x==0, y==0
- rgb  out  24  test-pattern pixel (see Configuration)

## Operation
- Two counters: hcnt 0..HTOT-1, vcnt 0..VTOT-1; hcnt wraps to 0 after HTOT-1 and increments vcnt; vcnt wraps to 0 after VTOT-1 at the same edge hcnt wraps.
- Line order: active [0,HDISP), front porch, sync [HDISP+HFP, HDISP+HFP+HPULSE), back porch. Frame order identical on vcnt.
- hs asserted while hcnt in horizontal sync window (every line, including vertical blanking); vs asserted while vcnt in vertical sync window, for whole lines.
- blank = (hcnt >= HDISP) or (vcnt >= VDISP).
- States: IDLE (en low or after reset) and RUN. IDLE: counters held at 0, hs/vs deasserted, blank=1, pulses 0. IDLE->RUN on en sampled high; RUN->IDLE on en sampled low, counters cleared immediately (no frame completion).
- Counters in RUN increment every clock; no stall input.

## Timing
- All outputs registered; outputs at cycle n+1 reflect counter values at cycle n.
- Reset (async): counters 0, hs=vs=deasserted level (!SYNC_POL), blank=1, x=y=0, line_start=frame_start=0, rgb=0. Reset mid-frame aborts immediately; after release generator waits in IDLE for en.
- First RUN cycle: counters (0,0); frame_start and line_start high one cycle later, together with blank=0, x=0, y=0.
- Period: line_start every HTOT cycles, frame_start every HTOT*VTOT cycles, exactly.
- en re-asserted after drop: restarts from (0,0), frame_start issued again.
- Elaboration error if any porch/pulse parameter is 0 or HDISP is not a multiple of 8.

## Configuration
- Macro VIDEO_TIMING_TEST_PATTERN_EN.
- Defined: rgb carries 8 vertical colour bars; bar index b = x / (HDISP/8) maintained by an incrementing bar counter (no divider), reset at each line; rgb = {b[2]?8'hFF:8'h00, b[1]?8'hFF:8'h00, b[0]?8'hFF:8'h00}; rgb=0 whenever blank. Aligned with x/blank (same cycle).
- Undefined: rgb tied to 24'h000000; no bar logic synthesised.

## Test plan
- Params HDISP=160 VDISP=90 HFP=4 HPULSE=8 HBP=12 VFP=1 VPULSE=2 VBP=3, reset pulse 128 ns then en=1 -> frame_start period 17664 cycles, line_start period 184 cycles.
- Same params -> hs low for exactly 8 cycles starting 164 cycles after line_start; vs low for 368 cycles starting 91 lines after frame_start; blank low exactly 160 cycles per active line, 90 active lines per frame.
- en dropped at x=50,y=30, re-raised 10 cycles later -> outputs idle (blank=1, hs=vs=1) during drop, frame_start one cycle after re-raise, x=y=0.
- Async reset asserted mid-line -> all outputs at reset values before the next clock edge; resumes only after en sampled high.
- SYNC_POL=1 -> hs/vs inverted versus SYNC_POL=0 run, idle level 0.
- With VIDEO_TIMING_TEST_PATTERN_EN -> rgb = 24'h000000 for x 0..19, 24'h0000FF for x 20..39, ..., 24'hFFFFFF for x 140..159, 0 during blank; without macro rgb constantly 0.

Source files
------------

// File: rtl/video_timing_if.sv
// Bundle between the raster timing generator and its consumers (framebuffer reader, video port).
// The master drives timing outputs and samples the run enable.
interface video_timing_if #(
  parameter int XW = 10,
  parameter int YW = 10
);
  logic          en;
  logic          hs;
  logic          vs;
  logic          blank;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          line_start;
  logic          frame_start;
  logic [23:0]   rgb;

  modport master (
    input  en,
    output hs, vs, blank, x, y, line_start, frame_start, rgb
  );

  modport slave (
    output en,
    input  hs, vs, blank, x, y, line_start, frame_start, rgb
  );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: syncs, blanking, coordinates and line/frame markers.
// Optional colour-bar test pattern on rgb when VIDEO_TIMING_TEST_PATTERN_EN is defined.
//
// state  | meaning
// IDLE   | counters held at 0, syncs deasserted, blank high
// RUN    | counters advance every pixel clock
module video_timing_gen #(
  parameter int HDISP    = 800,
  parameter int VDISP    = 480,
  parameter int HFP      = 40,
  parameter int HPULSE   = 48,
  parameter int HBP      = 40,
  parameter int VFP      = 13,
  parameter int VPULSE   = 3,
  parameter int VBP      = 29,
  parameter int SYNC_POL = 0
) (
  input  logic          clk_i,
  input  logic          reset_i,
  video_timing_if.master vt_io
);
  localparam int HTOT   = HDISP + HFP + HPULSE + HBP;
  localparam int VTOT   = VDISP + VFP + VPULSE + VBP;
  localparam int XW     = $clog2(HTOT);
  localparam int YW     = $clog2(VTOT);
  localparam int HS_BEG = HDISP + HFP;
  localparam int HS_END = HS_BEG + HPULSE;
  localparam int VS_BEG = VDISP + VFP;
  localparam int VS_END = VS_BEG + VPULSE;

  localparam logic SYNC_ON = (SYNC_POL != 0);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  if (HFP < 1 || HPULSE < 1 || HBP < 1 || VFP < 1 || VPULSE < 1 || VBP < 1 ||
      (HDISP % 8) != 0) begin : g_param_err
    $error("video_timing_gen: porch/pulse parameters must be nonzero and HDISP a multiple of 8");
  end

  logic [0:0]    state_q, state_d;
  logic [XW-1:0] hcnt_q, hcnt_d;
  logic [YW-1:0] vcnt_q, vcnt_d;
  logic          en_i;
  logic          run;
  logic          advance;
  logic          hwrap;
  logic          vwrap;

  assign en_i    = vt_io.en;
  assign run     = (state_q == S_RUN);
  assign advance = run && en_i;
  assign hwrap   = (hcnt_q == XW'(HTOT - 1));
  assign vwrap   = (vcnt_q == YW'(VTOT - 1));

  // Dropping en clears the counters on the same edge, so IDLE always sits at (0,0).
  always_comb begin
    state_d = en_i ? S_RUN : S_IDLE;
    hcnt_d  = '0;
    vcnt_d  = '0;
    if (advance) begin
      hcnt_d = hwrap ? '0 : hcnt_q + XW'(1);
      vcnt_d = vcnt_q;
      if (hwrap) begin
        vcnt_d = vwrap ? '0 : vcnt_q + YW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
    end
  end

  logic          hs_d, vs_d, blank_d, ls_d, fs_d;
  logic          hs_q, vs_q, blank_q, ls_q, fs_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;

  always_comb begin
    hs_d    = ~SYNC_ON;
    vs_d    = ~SYNC_ON;
    blank_d = 1'b1;
    ls_d    = 1'b0;
    fs_d    = 1'b0;
    if (run) begin
      if (hcnt_q >= XW'(HS_BEG) && hcnt_q < XW'(HS_END)) hs_d = SYNC_ON;
      if (vcnt_q >= YW'(VS_BEG) && vcnt_q < YW'(VS_END)) vs_d = SYNC_ON;
      blank_d = (hcnt_q >= XW'(HDISP)) || (vcnt_q >= YW'(VDISP));
      ls_d    = (hcnt_q == '0);
      fs_d    = (hcnt_q == '0) && (vcnt_q == '0);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hs_q    <= ~SYNC_ON;
      vs_q    <= ~SYNC_ON;
      blank_q <= 1'b1;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
      x_q     <= hcnt_q;
      y_q     <= vcnt_q;
    end
  end

  assign vt_io.hs          = hs_q;
  assign vt_io.vs          = vs_q;
  assign vt_io.blank       = blank_q;
  assign vt_io.x           = x_q;
  assign vt_io.y           = y_q;
  assign vt_io.line_start  = ls_q;
  assign vt_io.frame_start = fs_q;

`ifdef VIDEO_TIMING_TEST_PATTERN_EN
  localparam int BARW = HDISP / 8;

  // Bar position tracks hcnt_q, so the registered rgb lines up with x and blank.
  logic [XW-1:0] bpx_q;
  logic [2:0]    bar_q;
  logic [23:0]   rgb_d, rgb_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      bpx_q <= '0;
      bar_q <= '0;
    end else if (!advance || hwrap) begin
      bpx_q <= '0;
      bar_q <= '0;
    end else if (bpx_q == XW'(BARW - 1)) begin
      bpx_q <= '0;
      bar_q <= bar_q + 3'd1;
    end else begin
      bpx_q <= bpx_q + XW'(1);
    end
  end

  always_comb begin
    rgb_d = '0;
    if (!blank_d) rgb_d = {{8{bar_q[2]}}, {8{bar_q[1]}}, {8{bar_q[0]}}};
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) rgb_q <= '0;
    else         rgb_q <= rgb_d;
  end

  assign vt_io.rgb = rgb_q;
`else
  assign vt_io.rgb = 24'h000000;
`endif
endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen: two instances (SYNC_POL 0 and 1) against a
// positional raster model; define VIDEO_TIMING_TEST_PATTERN_EN to check the colour bars.
module tb_video_timing_gen;
  localparam int HDISP = 160, VDISP = 90, HFP = 4, HPULSE = 8, HBP = 12;
  localparam int VFP = 1, VPULSE = 2, VBP = 3;
  localparam int HTOT = HDISP + HFP + HPULSE + HBP;
  localparam int VTOT = VDISP + VFP + VPULSE + VBP;
  localparam int XW = $clog2(HTOT);
  localparam int YW = $clog2(VTOT);
  localparam int VW = 3 + XW + YW + 2 + 24;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  always #5 clk = ~clk;

  video_timing_if #(.XW(XW), .YW(YW)) vt0 ();
  video_timing_if #(.XW(XW), .YW(YW)) vt1 ();
  assign vt0.en = en;
  assign vt1.en = en;

  video_timing_gen #(.HDISP(HDISP), .VDISP(VDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
                     .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP), .SYNC_POL(0))
    dut0 (.clk_i(clk), .reset_i(reset), .vt_io(vt0));
  video_timing_gen #(.HDISP(HDISP), .VDISP(VDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
                     .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP), .SYNC_POL(1))
    dut1 (.clk_i(clk), .reset_i(reset), .vt_io(vt1));

  logic [VW-1:0] got0, got1, exp0, exp1;
  assign got0 = {vt0.hs, vt0.vs, vt0.blank, vt0.x, vt0.y, vt0.line_start, vt0.frame_start, vt0.rgb};
  assign got1 = {vt1.hs, vt1.vs, vt1.blank, vt1.x, vt1.y, vt1.line_start, vt1.frame_start, vt1.rgb};

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  bit run_m  = 1'b0;
  int pos_m  = 0;

  // Output expected one clock after the generator has run for pos cycles from (0,0).
  function automatic logic [VW-1:0] model(bit run, int pos, bit pol);
    int h, v, b;
    logic hs, vs, bl;
    logic [23:0] c;
    if (!run) return {~pol, ~pol, 1'b1, XW'(0), YW'(0), 1'b0, 1'b0, 24'h0};
    h  = pos % HTOT;
    v  = (pos / HTOT) % VTOT;
    hs = (h >= HDISP + HFP && h < HDISP + HFP + HPULSE) ? pol : ~pol;
    vs = (v >= VDISP + VFP && v < VDISP + VFP + VPULSE) ? pol : ~pol;
    bl = (h >= HDISP) || (v >= VDISP);
    c  = 24'h0;
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
    if (!bl) begin
      b = h / (HDISP / 8);
      c = {b[2] ? 8'hFF : 8'h00, b[1] ? 8'hFF : 8'h00, b[0] ? 8'hFF : 8'h00};
    end
`else
    b = 0;
`endif
    return {hs, vs, bl, XW'(h), YW'(v), (h == 0), (h == 0 && v == 0), c};
  endfunction

  task automatic cycle();
    @(posedge clk);
    cyc++;
    if (reset) begin
      run_m = 1'b0;
      pos_m = 0;
    end
    exp0 = model(run_m, pos_m, 1'b0);
    exp1 = model(run_m, pos_m, 1'b1);
    if (!reset) begin
      if (!en) begin
        run_m = 1'b0;
        pos_m = 0;
      end else if (run_m) begin
        pos_m++;
      end else begin
        run_m = 1'b1;
        pos_m = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    #7;
    exp0 = model(1'b0, 0, 1'b0);
    exp1 = model(1'b0, 0, 1'b1);
    checks++;
    if ({got0, got1} !== {exp0, exp1}) begin
      fails++;
      $display("FAIL reset_values got=%h/%h expected=%h/%h", got0, got1, exp0, exp1);
    end
    #121 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cycle();
      checks++;
      if ({got0, got1} !== {exp0, exp1}) begin
        fails++;
        $display("FAIL idle_after_reset cyc=%0d got=%h/%h expected=%h/%h", cyc, got0, got1, exp0, exp1);
      end
    end
  endtask

  task automatic test_periods();
    int last_ls, last_fs, nfs, bl_cnt, act, bad, prev_hs;
    last_ls = -1; last_fs = -1; nfs = 0; bl_cnt = 0; act = 0; bad = 0; prev_hs = 1;
    @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < HTOT * VTOT + 2 * HTOT + 4; i++) begin
      cycle();
      checks++;
      if ({got0, got1} !== {exp0, exp1}) begin
        fails++;
        $display("FAIL raster cyc=%0d got=%h/%h expected=%h/%h", cyc, got0, got1, exp0, exp1);
      end
      if (vt0.line_start === 1'b1) begin
        if (bl_cnt == HDISP) act++;
        else if (bl_cnt != 0) bad++;
        bl_cnt = 0;
        if (last_ls >= 0) begin
          checks++;
          if (cyc - last_ls != HTOT) begin
            fails++;
            $display("FAIL line_period got=%0d expected=%0d", cyc - last_ls, HTOT);
          end
        end
        last_ls = cyc;
      end
      if (vt0.frame_start === 1'b1) begin
        nfs++;
        if (last_fs >= 0) begin
          checks++;
          if (cyc - last_fs != HTOT * VTOT) begin
            fails++;
            $display("FAIL frame_period got=%0d expected=%0d", cyc - last_fs, HTOT * VTOT);
          end
          checks++;
          if (act != VDISP || bad != 0) begin
            fails++;
            $display("FAIL active_lines got=%0d (partial %0d) expected=%0d", act, bad, VDISP);
          end
        end
        act = 0; bad = 0;
        last_fs = cyc;
      end
      if (vt0.blank === 1'b0) bl_cnt++;
      if (vt0.hs === 1'b0 && prev_hs == 1 && last_ls >= 0) begin
        checks++;
        if (cyc - last_ls != HDISP + HFP) begin
          fails++;
          $display("FAIL hs_offset got=%0d expected=%0d", cyc - last_ls, HDISP + HFP);
        end
      end
      prev_hs = (vt0.hs === 1'b0) ? 0 : 1;
    end
    checks++;
    if (nfs != 2) begin
      fails++;
      $display("FAIL frame_count got=%0d expected=2", nfs);
    end
  endtask

  task automatic test_en_drop();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2 * HTOT * VTOT && !found; i++) begin
      @(negedge clk);
      cycle();
      checks++;
      if ({got0, got1} !== {exp0, exp1}) begin
        fails++;
        $display("FAIL seek cyc=%0d got=%h/%h expected=%h/%h", cyc, got0, got1, exp0, exp1);
      end
      if (vt0.x == XW'(50) && vt0.y == YW'(30)) found = 1'b1;
    end
    checks++;
    if (!found) begin
      fails++;
      $display("FAIL seek_timeout got=no x50/y30 expected=x50/y30");
    end
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++;
      if ({got0, got1} !== {exp0, exp1}) begin
        fails++;
        $display("FAIL en_low cyc=%0d got=%h/%h expected=%h/%h", cyc, got0, got1, exp0, exp1);
      end
      if (i > 0) begin
        checks++;
        if ({vt0.hs, vt0.vs, vt0.blank} !== 3'b111) begin
          fails++;
          $display("FAIL idle_levels got=%b expected=111", {vt0.hs, vt0.vs, vt0.blank});
        end
      end
      @(negedge clk);
    end
    en = 1'b1;
    cycle();
    checks++;
    if (vt0.frame_start !== 1'b0 || vt0.blank !== 1'b1) begin
      fails++;
      $display("FAIL restart_edge1 got fs=%b blank=%b expected fs=0 blank=1", vt0.frame_start, vt0.blank);
    end
    cycle();
    checks++;
    if ({vt0.frame_start, vt0.line_start, vt0.blank, vt0.x, vt0.y} !== {1'b1, 1'b1, 1'b0, XW'(0), YW'(0)}) begin
      fails++;
      $display("FAIL restart fs=%b ls=%b blank=%b x=%0d y=%0d expected fs=1 ls=1 blank=0 x=0 y=0",
               vt0.frame_start, vt0.line_start, vt0.blank, vt0.x, vt0.y);
    end
  endtask

  task automatic test_random_en();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) < 3) en = ~en;
      cycle();
      checks++;
      if ({got0, got1} !== {exp0, exp1}) begin
        fails++;
        $display("FAIL random_en cyc=%0d got=%h/%h expected=%h/%h", cyc, got0, got1, exp0, exp1);
      end
    end
  endtask

  task automatic test_async_reset();
    int n;
    @(negedge clk);
    en = 1'b1;
    n = $urandom_range(200, 600);
    for (int i = 0; i < n; i++) begin
      cycle();
      @(negedge clk);
    end
    #2 reset = 1'b1;
    run_m = 1'b0;
    pos_m = 0;
    #1;
    exp0 = model(1'b0, 0, 1'b0);
    exp1 = model(1'b0, 0, 1'b1);
    checks++;
    if ({got0, got1} !== {exp0, exp1}) begin
      fails++;
      $display("FAIL async_reset got=%h/%h expected=%h/%h", got0, got1, exp0, exp1);
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (i == 5) en = 1'b1;
      cycle();
      checks++;
      if ({got0, got1} !== {exp0, exp1}) begin
        fails++;
        $display("FAIL after_reset cyc=%0d got=%h/%h expected=%h/%h", cyc, got0, got1, exp0, exp1);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_pattern();
    logic [23:0] bars [8];
    logic [23:0] want;
    bit found;
    bars = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
             24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF};
    found = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 2 * HTOT * VTOT && !found; i++) begin
      cycle();
      if (vt0.x == XW'(0) && vt0.y == YW'(5) && vt0.blank === 1'b0) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      fails++;
      $display("FAIL pattern_seek got=no line 5 expected=line 5");
    end
    for (int i = 0; i < HTOT; i++) begin
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
      want = (i < HDISP) ? bars[i / (HDISP / 8)] : 24'h000000;
`else
      want = 24'h000000;
`endif
      checks++;
      if (vt0.rgb !== want || vt1.rgb !== want || vt0.x !== XW'(i)) begin
        fails++;
        $display("FAIL pattern x=%0d got rgb=%h/%h xo=%0d expected rgb=%h", i, vt0.rgb, vt1.rgb, vt0.x, want);
      end
      @(negedge clk);
      cycle();
    end
  endtask

  initial begin
    test_reset();
    test_periods();
    test_en_drop();
    test_random_en();
    test_async_reset();
    test_pattern();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
